// File: rtl/register_file.sv
// General-purpose register bank: DEPTH x WIDTH, one write port, two registered
// read ports with write-to-read forwarding and optional tri-state idle outputs.
module register_file #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          TRISTATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  output logic [DEPTH-1:0] written
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] held_a, held_b;
  logic [WIDTH-1:0] next_a, next_b;
  logic             wr_ok;

  always_comb begin
    wr_ok  = wr_en && !(ZERO_REG && (wr_addr == '0));
    next_a = mem[rd_addr_a];
    next_b = mem[rd_addr_b];
    // Forward only accepted writes; the hard-wired zero entry wins over both.
    if (wr_ok && (rd_addr_a == wr_addr)) next_a = wr_data;
    if (wr_ok && (rd_addr_b == wr_addr)) next_b = wr_data;
    if (ZERO_REG && (rd_addr_a == '0)) next_a = '0;
    if (ZERO_REG && (rd_addr_b == '0)) next_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem        <= '{default: '0};
      held_a     <= '0;
      held_b     <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      written    <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr]     <= wr_data;
        written[wr_addr] <= 1'b1;
      end
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) held_a <= next_a;
      if (rd_en_b) held_b <= next_b;
    end
  end

  generate
    if (TRISTATE) begin : g_tri
      assign rd_data_a = rd_valid_a ? held_a : {WIDTH{1'bz}};
      assign rd_data_b = rd_valid_b ? held_b : {WIDTH{1'bz}};
    end else begin : g_zero
      assign rd_data_a = rd_valid_a ? held_a : '0;
      assign rd_data_b = rd_valid_b ? held_b : '0;
    end
  endgenerate

endmodule
